// File: rtl/priority_resolver_n_if.sv
// rtl/priority_resolver_n_if.sv - request, acknowledge and EOI bundle between IRR block, CPU bus and priority resolver
interface priority_resolver_n_if #(
    parameter int NUM_IRQ = 8
);
    localparam int IDX_W = $clog2(NUM_IRQ);

    logic [NUM_IRQ-1:0] irr;
    logic [NUM_IRQ-1:0] imr;
    logic               inta_n;
    logic               rotate_en;
    logic               aeoi;
    logic               eoi_valid;
    logic               eoi_specific;
    logic [IDX_W-1:0]   eoi_level;
    logic               int_out;
    logic [NUM_IRQ-1:0] isr;
    logic [NUM_IRQ-1:0] irr_clr;
    logic [IDX_W-1:0]   vec_idx;
    logic               vec_valid;

    modport master (
        output irr, imr, inta_n, rotate_en, aeoi, eoi_valid, eoi_specific, eoi_level,
        input  int_out, isr, irr_clr, vec_idx, vec_valid
    );

    modport slave (
        input  irr, imr, inta_n, rotate_en, aeoi, eoi_valid, eoi_specific, eoi_level,
        output int_out, isr, irr_clr, vec_idx, vec_valid
    );
endinterface

// File: rtl/priority_resolver_n.sv
// rtl/priority_resolver_n.sv - N-channel nested priority resolver with rotation, EOI/AEOI and two-pulse INTA sequencing
module priority_resolver_n #(
    parameter int NUM_IRQ = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    priority_resolver_n_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_IRQ);
    localparam logic [IDX_W-1:0] LP_FIXED = IDX_W'(NUM_IRQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK1  = 2'd1,
        WAIT2 = 2'd2,
        ACK2  = 2'd3
    } state_t;

    state_t             state;
    logic               inta_q;
    logic [IDX_W-1:0]   lp;
    logic               spurious;
    logic [NUM_IRQ-1:0] isr_q;
    logic [NUM_IRQ-1:0] irr_clr_q;
    logic [IDX_W-1:0]   vec_idx_q;
    logic               int_q;
    logic               vec_valid_q;

    logic [IDX_W-1:0]   lp_eff;
    logic [NUM_IRQ-1:0] req;
    logic               cand_found;
    logic [IDX_W-1:0]   cand_idx;
    int                 cand_rank;
    logic               top_found;
    logic [IDX_W-1:0]   top_idx;
    int                 top_rank;
    logic               eligible;

    logic               lvl_ok;
    logic               eoi_hit;
    logic [IDX_W-1:0]   eoi_lvl;
    logic [NUM_IRQ-1:0] eoi_mask;

    logic               fall;
    logic               rise;
    logic               ack_take;
    logic [NUM_IRQ-1:0] set_mask;
    logic               aeoi_hit;
    logic [NUM_IRQ-1:0] aeoi_mask;
    logic               to_idle;

    assign bus.int_out   = int_q;
    assign bus.isr       = isr_q;
    assign bus.irr_clr   = irr_clr_q;
    assign bus.vec_idx   = vec_idx_q;
    assign bus.vec_valid = vec_valid_q;

    // Scan channels by rank (0 = highest, just after lp); the lowest-rank pending and in-service bits win
    always_comb begin
        int ch;
        ch         = 0;
        lp_eff     = bus.rotate_en ? lp : LP_FIXED;
        req        = bus.irr & ~bus.imr;
        cand_found = 1'b0;
        cand_idx   = '0;
        cand_rank  = 0;
        top_found  = 1'b0;
        top_idx    = '0;
        top_rank   = 0;
        for (int r = NUM_IRQ - 1; r >= 0; r--) begin
            ch = int'(lp_eff) + 1 + r;
            if (ch >= NUM_IRQ) begin
                ch = ch - NUM_IRQ;
            end
            if (req[IDX_W'(ch)]) begin
                cand_found = 1'b1;
                cand_idx   = IDX_W'(ch);
                cand_rank  = r;
            end
            if (isr_q[IDX_W'(ch)]) begin
                top_found = 1'b1;
                top_idx   = IDX_W'(ch);
                top_rank  = r;
            end
        end
        eligible = cand_found && (!top_found || (cand_rank < top_rank));
    end

    // Resolve which ISR level an EOI strobe clears; its level always comes from the pre-update ISR
    always_comb begin
        lvl_ok   = 1'b0;
        eoi_hit  = 1'b0;
        eoi_lvl  = '0;
        eoi_mask = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (bus.eoi_level == IDX_W'(k)) begin
                lvl_ok = 1'b1;
            end
        end
        if (bus.eoi_valid) begin
            if (!bus.eoi_specific) begin
                eoi_hit = top_found;
                eoi_lvl = top_idx;
            end else if (lvl_ok) begin
                eoi_hit = isr_q[bus.eoi_level];
                eoi_lvl = bus.eoi_level;
            end
        end
        if (eoi_hit) begin
            eoi_mask[eoi_lvl] = 1'b1;
        end
    end

    // INTA edge decode plus the ISR set/clear masks produced by the acknowledge sequence
    always_comb begin
        fall      = inta_q & ~bus.inta_n;
        rise      = ~inta_q & bus.inta_n;
        ack_take  = (state == IDLE) && fall && eligible;
        set_mask  = '0;
        if (ack_take) begin
            set_mask[cand_idx] = 1'b1;
        end
        aeoi_hit  = (state == ACK2) && rise && bus.aeoi && !spurious;
        aeoi_mask = '0;
        if (aeoi_hit) begin
            aeoi_mask[vec_idx_q] = 1'b1;
        end
        to_idle   = ((state == IDLE) && !fall) || ((state == ACK2) && rise);
    end

    // Acknowledge FSM with registered outputs; ISR set beats any clear on the same bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            inta_q      <= 1'b1;
            lp          <= LP_FIXED;
            spurious    <= 1'b0;
            isr_q       <= '0;
            irr_clr_q   <= '0;
            vec_idx_q   <= '0;
            int_q       <= 1'b0;
            vec_valid_q <= 1'b0;
        end else begin
            inta_q    <= bus.inta_n;
            irr_clr_q <= set_mask;
            isr_q     <= (isr_q & ~eoi_mask & ~aeoi_mask) | set_mask;
            int_q     <= eligible && to_idle;

            if (!bus.rotate_en) begin
                lp <= LP_FIXED;
            end else if (aeoi_hit) begin
                lp <= vec_idx_q;
            end else if (eoi_hit) begin
                lp <= eoi_lvl;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state <= ACK1;
                        if (eligible) begin
                            vec_idx_q <= cand_idx;
                            spurious  <= 1'b0;
                        end else begin
                            vec_idx_q <= LP_FIXED;
                            spurious  <= 1'b1;
                        end
                    end
                end
                ACK1: begin
                    if (rise) begin
                        state <= WAIT2;
                    end
                end
                WAIT2: begin
                    if (fall) begin
                        state       <= ACK2;
                        vec_valid_q <= 1'b1;
                    end
                end
                ACK2: begin
                    if (rise) begin
                        state       <= IDLE;
                        vec_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_priority_resolver_n.sv
// tb/tb_priority_resolver_n.sv - self-checking bench for priority_resolver_n with behavioural model and directed scenarios
module tb_priority_resolver_n;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    priority_resolver_n_if #(.NUM_IRQ(N)) bus();

    priority_resolver_n #(.NUM_IRQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;
    bit rnd_eoi = 1'b0;
    int last_vec = -1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int prio(input int c, input int lp);
        return (c - lp - 1 + N) % N;
    endfunction

    function automatic int highest(input bit [N-1:0] m, input int lp);
        int best;
        best = -1;
        for (int c = 0; c < N; c++) begin
            if (m[c] && (best < 0 || prio(c, lp) < prio(best, lp))) begin
                best = c;
            end
        end
        return best;
    endfunction

    int       m_st;
    bit [N-1:0] m_isr;
    bit [N-1:0] m_clr;
    int       m_lp;
    int       m_vec;
    bit       m_spur;
    bit       m_int;
    bit       m_vv;
    bit       m_prev;

    always @(posedge clk or negedge rst_n) begin
        int lpe, cand, top, el, nlp, nst;
        bit elig, fall, rise;
        bit [N-1:0] nisr;
        if (!rst_n) begin
            m_st = 0; m_isr = '0; m_clr = '0; m_lp = N - 1; m_vec = 0;
            m_spur = 1'b0; m_int = 1'b0; m_vv = 1'b0; m_prev = 1'b1;
        end else begin
            lpe  = bus.rotate_en ? m_lp : N - 1;
            fall = m_prev && !bus.inta_n;
            rise = !m_prev && bus.inta_n;
            m_prev = bus.inta_n;
            cand = highest(bus.irr & ~bus.imr, lpe);
            top  = highest(m_isr, lpe);
            elig = (cand >= 0) && (top < 0 || prio(cand, lpe) < prio(top, lpe));
            el = -1;
            if (bus.eoi_valid) begin
                if (!bus.eoi_specific) el = top;
                else if (m_isr[bus.eoi_level]) el = int'(bus.eoi_level);
            end
            nisr = m_isr;
            nlp  = m_lp;
            if (el >= 0) begin
                nisr[el] = 1'b0;
                if (bus.rotate_en) nlp = el;
            end
            m_clr = '0;
            nst = m_st;
            case (m_st)
                0: if (fall) begin
                    nst = 1;
                    if (elig) begin
                        nisr[cand] = 1'b1; m_clr[cand] = 1'b1; m_vec = cand; m_spur = 1'b0;
                    end else begin
                        m_vec = N - 1; m_spur = 1'b1;
                    end
                end
                1: if (rise) nst = 2;
                2: if (fall) begin nst = 3; m_vv = 1'b1; end
                3: if (rise) begin
                    nst = 0; m_vv = 1'b0;
                    if (bus.aeoi && !m_spur) begin
                        nisr[m_vec] = 1'b0;
                        if (bus.rotate_en) nlp = m_vec;
                    end
                end
                default: nst = 0;
            endcase
            if (!bus.rotate_en) nlp = N - 1;
            m_int = elig && (nst == 0);
            m_isr = nisr;
            m_lp  = nlp;
            m_st  = nst;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            check("int_out",   32'(bus.int_out),   32'(m_int));
            check("isr",       32'(bus.isr),       32'(m_isr));
            check("irr_clr",   32'(bus.irr_clr),   32'(m_clr));
            check("vec_valid", 32'(bus.vec_valid), 32'(m_vv));
            check("vec_idx",   32'(bus.vec_idx),   m_vec);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            bus.irr = bus.irr & ~bus.irr_clr;
            if (rnd_eoi && $urandom_range(3) == 0) begin
                bus.eoi_valid    = 1'b1;
                bus.eoi_specific = 1'($urandom_range(1));
                bus.eoi_level    = 3'($urandom_range(N - 1));
            end else begin
                bus.eoi_valid = 1'b0;
            end
        end
    endtask

    task automatic inta_pulse(input int lo, input int hi);
        bus.inta_n = 1'b0;
        step(lo);
        if (bus.vec_valid) last_vec = int'(bus.vec_idx);
        bus.inta_n = 1'b1;
        step(hi);
    endtask

    task automatic full_ack();
        inta_pulse(1, 1);
        inta_pulse(1, 1);
    endtask

    task automatic eoi_ns();
        bus.eoi_valid = 1'b1; bus.eoi_specific = 1'b0;
        step();
    endtask

    task automatic eoi_sp(input int lvl);
        bus.eoi_valid = 1'b1; bus.eoi_specific = 1'b1; bus.eoi_level = 3'(lvl);
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.irr = '0; bus.imr = '0; bus.inta_n = 1'b1; bus.rotate_en = 1'b0; bus.aeoi = 1'b0;
        bus.eoi_valid = 1'b0; bus.eoi_specific = 1'b0; bus.eoi_level = '0;
        step(2);
        check("rst_int_out", 32'(bus.int_out), 0);
        check("rst_isr", 32'(bus.isr), 0);
        check("rst_irr_clr", 32'(bus.irr_clr), 0);
        check("rst_vec_idx", 32'(bus.vec_idx), 0);
        check("rst_vec_valid", 32'(bus.vec_valid), 0);
        rst_n = 1'b1;
        chk_on = 1'b1;
        step();
        check("model_rot_pick", highest(8'h09, 3), 0);
        check("model_fixed_pick", highest(8'h24, 7), 2);

        // fixed mode basic acknowledge
        check("s1_int_idle", 32'(bus.int_out), 0);
        bus.irr = 8'h24; step();
        check("s1_int_on", 32'(bus.int_out), 1);
        bus.inta_n = 1'b0; step();
        check("s1_isr", 32'(bus.isr), 32'h04);
        check("s1_irr_clr", 32'(bus.irr_clr), 32'h04);
        check("s1_int_ack1", 32'(bus.int_out), 0);
        bus.inta_n = 1'b1; step();
        check("s1_irr_clr_end", 32'(bus.irr_clr), 0);
        bus.inta_n = 1'b0; step();
        check("s1_vec_valid", 32'(bus.vec_valid), 1);
        check("s1_vec_idx", 32'(bus.vec_idx), 2);
        bus.inta_n = 1'b1; step();
        check("s1_vec_valid_off", 32'(bus.vec_valid), 0);
        eoi_ns();
        check("s1_eoi", 32'(bus.isr), 0);
        bus.irr = '0; step(2);

        // nesting
        bus.irr = 8'h10; step(); full_ack();
        check("s2_isr4", 32'(bus.isr), 32'h10);
        bus.irr = 8'h20; step(2);
        check("s2_blocked", 32'(bus.int_out), 0);
        bus.irr = 8'h02; step();
        check("s2_nest_int", 32'(bus.int_out), 1);
        full_ack();
        check("s2_isr_nested", 32'(bus.isr), 32'h12);
        eoi_ns();
        check("s2_eoi_top", 32'(bus.isr), 32'h10);
        eoi_ns();
        bus.irr = '0; step();

        // rotating priority
        bus.rotate_en = 1'b1;
        bus.irr = 8'h08; step(); full_ack();
        check("s3_isr3", 32'(bus.isr), 32'h08);
        eoi_ns();
        bus.irr = 8'h21; step(); full_ack();
        check("s3_vec_after_lp3", last_vec, 5);
        eoi_ns();
        bus.irr = 8'h09; step(); full_ack();
        check("s3_vec_ir0", last_vec, 0);
        eoi_ns();
        bus.irr = '0; bus.rotate_en = 1'b0; step(2);

        // automatic EOI with rotation
        bus.rotate_en = 1'b1; bus.aeoi = 1'b1;
        bus.irr = 8'h04; step(); full_ack();
        check("s4_aeoi_ir2", 32'(bus.isr), 0);
        bus.irr = 8'h80; step(); full_ack();
        check("s4_aeoi_ir7", 32'(bus.isr), 0);
        bus.irr = 8'h0C; step(); full_ack();
        check("s4_vec_lp7", last_vec, 2);
        bus.irr = '0; bus.aeoi = 1'b0; bus.rotate_en = 1'b0; step(2);

        // spurious acknowledge and masking
        bus.irr = 8'h01; step();
        check("s5_int", 32'(bus.int_out), 1);
        bus.irr = '0; bus.inta_n = 1'b0; step();
        check("s5_no_clr", 32'(bus.irr_clr), 0);
        check("s5_isr", 32'(bus.isr), 0);
        bus.inta_n = 1'b1; step();
        bus.inta_n = 1'b0; step();
        check("s5_vec_spur", 32'(bus.vec_idx), 7);
        bus.inta_n = 1'b1; step();
        check("s5_isr_end", 32'(bus.isr), 0);
        bus.imr = 8'h01; bus.irr = 8'h01; step(2);
        check("s5_masked", 32'(bus.int_out), 0);
        bus.imr = '0; bus.irr = '0; step();

        // simultaneous EOI and acknowledge, then reset mid-sequence
        bus.irr = 8'h04; step();
        bus.inta_n = 1'b0; eoi_sp(2);
        check("s6_same_bit", 32'(bus.isr), 32'h04);
        bus.inta_n = 1'b1; step(); bus.inta_n = 1'b0; step(); bus.inta_n = 1'b1; step();
        eoi_sp(2);
        bus.irr = 8'h10; step(); full_ack();
        bus.irr = 8'h04; step();
        bus.inta_n = 1'b0; eoi_sp(4);
        check("s6_diff_bit", 32'(bus.isr), 32'h04);
        bus.inta_n = 1'b1; step();
        #2 rst_n = 1'b0;
        #1;
        check("s6_rst_isr", 32'(bus.isr), 0);
        check("s6_rst_int", 32'(bus.int_out), 0);
        check("s6_rst_vv", 32'(bus.vec_valid), 0);
        check("s6_rst_vec", 32'(bus.vec_idx), 0);
        check("s6_rst_clr", 32'(bus.irr_clr), 0);
        bus.irr = '0; step();
        rst_n = 1'b1; step(2);
        check("s6_after_rst", 32'(bus.isr), 0);

        // randomized traffic against the model
        rnd_eoi = 1'b1;
        for (int it = 0; it < 60; it++) begin
            bus.rotate_en = 1'($urandom_range(1));
            bus.aeoi      = ($urandom_range(3) == 0);
            bus.imr       = 8'($urandom) & 8'($urandom) & 8'($urandom);
            bus.irr       = bus.irr | (8'($urandom) & 8'($urandom));
            step($urandom_range(3, 1));
            inta_pulse($urandom_range(3, 1), $urandom_range(3, 1));
            inta_pulse($urandom_range(3, 1), $urandom_range(3, 1));
            step($urandom_range(2, 0));
        end
        rnd_eoi = 1'b0;
        step(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
